// File: rtl/ccl_object_table.sv
// ccl_object_table
//
// Per-frame object table for the connected-components path. Labelled pixels
// update a per-label record (area, x/y sums, bounding box). Label-equivalence
// pairs are queued in a merge FIFO. At frame end the pairs are resolved by
// union-find, children are folded into their roots, and one record per final
// object is streamed out.
//
// Ports
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   frame_start                start of frame (honoured in IDLE only)
//   pix_valid/label/x/y        labelled pixel stream (used in ACCUM only)
//   merge_valid/a/b            equivalence pair stream (used in ACCUM only)
//   frame_end, num_labels      end of frame and number of labels allocated
//   busy                       high while clearing or resolving/emitting
//   obj_*                      object record, valid/ready handshake
//   frame_done                 one-cycle pulse when the record stream ends
//   merge_overflow             sticky: a merge pair was dropped on a full FIFO
//   dbg_state                  current FSM state encoding
//
// Handshake: a record transfers on a rising edge where obj_valid && obj_ready.
// While obj_valid is high and obj_ready is low, every obj_* field holds.
module ccl_object_table #(
    parameter int LABEL_WIDTH = 8,
    parameter int COORD_WIDTH = 16,
    parameter int ACC_WIDTH   = 32,
    parameter int MERGE_DEPTH = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   frame_start,
    input  logic                   pix_valid,
    input  logic [LABEL_WIDTH-1:0] pix_label,
    input  logic [COORD_WIDTH-1:0] pix_x,
    input  logic [COORD_WIDTH-1:0] pix_y,
    input  logic                   merge_valid,
    input  logic [LABEL_WIDTH-1:0] merge_a,
    input  logic [LABEL_WIDTH-1:0] merge_b,
    input  logic                   frame_end,
    input  logic [LABEL_WIDTH-1:0] num_labels,
    output logic                   busy,
    output logic                   obj_valid,
    input  logic                   obj_ready,
    output logic [LABEL_WIDTH-1:0] obj_label,
    output logic [ACC_WIDTH-1:0]   obj_area,
    output logic [ACC_WIDTH-1:0]   obj_sum_x,
    output logic [ACC_WIDTH-1:0]   obj_sum_y,
    output logic [COORD_WIDTH-1:0] obj_min_x,
    output logic [COORD_WIDTH-1:0] obj_max_x,
    output logic [COORD_WIDTH-1:0] obj_min_y,
    output logic [COORD_WIDTH-1:0] obj_max_y,
    output logic                   obj_last,
    output logic                   frame_done,
    output logic                   merge_overflow,
    output logic [3:0]             dbg_state
);
    localparam int NUM_LABELS = 2**LABEL_WIDTH;
    localparam int PW         = $clog2(MERGE_DEPTH);
    localparam logic [LABEL_WIDTH-1:0] L_ONE   = 1;
    localparam logic [ACC_WIDTH-1:0]   ACC_ONE = 1;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_CLEAR     = 4'd1,
        S_ACCUM     = 4'd2,
        S_UNION_POP = 4'd3,
        S_FIND_A    = 4'd4,
        S_FIND_B    = 4'd5,
        S_LINK      = 4'd6,
        S_FOLD      = 4'd7,
        S_EMIT      = 4'd8
    } state_t;

    state_t r_state, w_state_next;

    // Label table. Reads are combinational so a pixel's read-modify-write
    // completes in one cycle and a following pixel sees the updated value.
    logic [LABEL_WIDTH-1:0] r_parent [NUM_LABELS];
    logic [ACC_WIDTH-1:0]   r_area   [NUM_LABELS];
    logic [ACC_WIDTH-1:0]   r_sum_x  [NUM_LABELS];
    logic [ACC_WIDTH-1:0]   r_sum_y  [NUM_LABELS];
    logic [COORD_WIDTH-1:0] r_min_x  [NUM_LABELS];
    logic [COORD_WIDTH-1:0] r_max_x  [NUM_LABELS];
    logic [COORD_WIDTH-1:0] r_min_y  [NUM_LABELS];
    logic [COORD_WIDTH-1:0] r_max_y  [NUM_LABELS];

    // Merge FIFO; pointers carry one extra bit to tell full from empty.
    logic [LABEL_WIDTH-1:0] r_fifo_a [MERGE_DEPTH];
    logic [LABEL_WIDTH-1:0] r_fifo_b [MERGE_DEPTH];
    logic [PW:0]            r_wr_ptr, r_rd_ptr;

    logic [LABEL_WIDTH-1:0] r_idx;   // clear / fold / emit scan index
    logic [LABEL_WIDTH-1:0] r_n;     // num_labels latched at frame_end
    logic [LABEL_WIDTH-1:0] r_ra, r_rb;
    logic [LABEL_WIDTH-1:0] r_last;  // highest root that will be emitted

    function automatic logic [ACC_WIDTH-1:0] sat_add(input logic [ACC_WIDTH-1:0] a,
                                                     input logic [ACC_WIDTH-1:0] b);
        logic [ACC_WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[ACC_WIDTH] ? '1 : s[ACC_WIDTH-1:0];
    endfunction

    logic                   w_fifo_empty, w_fifo_full, w_push;
    logic [LABEL_WIDTH-1:0] w_par_ra, w_par_rb, w_par_i, w_root;
    logic                   w_fold_move, w_emit_qual, w_scan_end, w_fold_end;
    logic [LABEL_WIDTH-1:0] w_last_cand;
    logic                   w_busy_next;

    assign w_fifo_empty = (r_wr_ptr == r_rd_ptr);
    assign w_fifo_full  = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                          (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
    assign w_push       = (r_state == S_ACCUM) && merge_valid && (merge_a != merge_b) &&
                          (merge_a != '0) && (merge_b != '0);

    assign w_par_ra    = r_parent[r_ra];
    assign w_par_rb    = r_parent[r_rb];
    assign w_par_i     = r_parent[r_idx];
    // parent[i] < i has already been flattened, so one more hop is the root.
    assign w_root      = r_parent[w_par_i];
    assign w_fold_move = (w_root != r_idx);
    assign w_fold_end  = (r_idx == (r_n - L_ONE));
    assign w_last_cand = w_fold_move ? w_root : r_idx;

    assign w_emit_qual = (w_par_i == r_idx) && (r_area[r_idx] != '0);
    assign w_scan_end  = (r_idx >= r_n);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_CLEAR;
        else       r_state <= w_state_next;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:      if (frame_start) w_state_next = S_CLEAR;
            S_CLEAR:     if (r_idx == '1) w_state_next = S_ACCUM;
            S_ACCUM:     if (frame_end) w_state_next = S_UNION_POP;
            S_UNION_POP: begin
                if (!w_fifo_empty)   w_state_next = S_FIND_A;
                else if (r_n <= L_ONE) w_state_next = S_EMIT;
                else                 w_state_next = S_FOLD;
            end
            S_FIND_A:    if (w_par_ra == r_ra) w_state_next = S_FIND_B;
            S_FIND_B:    if (w_par_rb == r_rb) w_state_next = S_LINK;
            S_LINK:      w_state_next = S_UNION_POP;
            S_FOLD:      if (w_fold_end) w_state_next = S_EMIT;
            S_EMIT:      if (!obj_valid && w_scan_end) w_state_next = S_IDLE;
            default:     w_state_next = S_CLEAR;
        endcase
    end

    // ---------------- FSM: output decode ----------------
    always_comb begin
        w_busy_next = !((w_state_next == S_IDLE) || (w_state_next == S_ACCUM));
        dbg_state   = r_state;
    end

    // ---------------- Control and output registers ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            busy           <= 1'b0;
            frame_done     <= 1'b0;
            merge_overflow <= 1'b0;
            obj_valid      <= 1'b0;
            obj_label      <= '0;
            obj_area       <= '0;
            obj_sum_x      <= '0;
            obj_sum_y      <= '0;
            obj_min_x      <= '0;
            obj_max_x      <= '0;
            obj_min_y      <= '0;
            obj_max_y      <= '0;
            obj_last       <= 1'b0;
            r_idx          <= '0;
            r_n            <= '0;
            r_ra           <= '0;
            r_rb           <= '0;
            r_last         <= '0;
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
        end else begin
            busy       <= w_busy_next;
            frame_done <= 1'b0;
            case (r_state)
                S_IDLE: if (frame_start) r_idx <= '0;
                S_CLEAR: begin
                    r_idx          <= r_idx + L_ONE;
                    r_wr_ptr       <= '0;
                    r_rd_ptr       <= '0;
                    merge_overflow <= 1'b0;
                    r_last         <= '0;
                end
                S_ACCUM: begin
                    if (w_push) begin
                        if (w_fifo_full) merge_overflow <= 1'b1;
                        else             r_wr_ptr <= r_wr_ptr + 1'b1;
                    end
                    if (frame_end) r_n <= num_labels;
                end
                S_UNION_POP: begin
                    if (!w_fifo_empty) begin
                        r_ra     <= r_fifo_a[r_rd_ptr[PW-1:0]];
                        r_rb     <= r_fifo_b[r_rd_ptr[PW-1:0]];
                        r_rd_ptr <= r_rd_ptr + 1'b1;
                    end else begin
                        r_idx <= L_ONE;
                    end
                end
                S_FIND_A: if (w_par_ra != r_ra) r_ra <= w_par_ra;
                S_FIND_B: if (w_par_rb != r_rb) r_rb <= w_par_rb;
                S_FOLD: begin
                    // A root ends up non-empty if it or any child held pixels.
                    if ((r_area[r_idx] != '0) && (w_last_cand > r_last))
                        r_last <= w_last_cand;
                    r_idx <= w_fold_end ? L_ONE : (r_idx + L_ONE);
                end
                S_EMIT: begin
                    if (obj_valid) begin
                        if (obj_ready) begin
                            obj_valid <= 1'b0;
                            obj_last  <= 1'b0;
                        end
                    end else if (w_scan_end) begin
                        frame_done <= 1'b1;
                    end else begin
                        if (w_emit_qual) begin
                            obj_valid <= 1'b1;
                            obj_label <= r_idx;
                            obj_area  <= r_area[r_idx];
                            obj_sum_x <= r_sum_x[r_idx];
                            obj_sum_y <= r_sum_y[r_idx];
                            obj_min_x <= r_min_x[r_idx];
                            obj_max_x <= r_max_x[r_idx];
                            obj_min_y <= r_min_y[r_idx];
                            obj_max_y <= r_max_y[r_idx];
                            obj_last  <= (r_idx == r_last);
                        end
                        r_idx <= r_idx + L_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- Merge FIFO storage ----------------
    always_ff @(posedge clk) begin
        if (!reset && w_push && !w_fifo_full) begin
            r_fifo_a[r_wr_ptr[PW-1:0]] <= merge_a;
            r_fifo_b[r_wr_ptr[PW-1:0]] <= merge_b;
        end
    end

    // ---------------- Label table writes ----------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            case (r_state)
                S_CLEAR: begin
                    r_parent[r_idx] <= r_idx;
                    r_area[r_idx]   <= '0;
                    r_sum_x[r_idx]  <= '0;
                    r_sum_y[r_idx]  <= '0;
                    r_min_x[r_idx]  <= '1;
                    r_max_x[r_idx]  <= '0;
                    r_min_y[r_idx]  <= '1;
                    r_max_y[r_idx]  <= '0;
                end
                S_ACCUM: begin
                    if (pix_valid && (pix_label != '0)) begin
                        r_area[pix_label]  <= sat_add(r_area[pix_label], ACC_ONE);
                        r_sum_x[pix_label] <= sat_add(r_sum_x[pix_label], ACC_WIDTH'(pix_x));
                        r_sum_y[pix_label] <= sat_add(r_sum_y[pix_label], ACC_WIDTH'(pix_y));
                        if (pix_x < r_min_x[pix_label]) r_min_x[pix_label] <= pix_x;
                        if (pix_x > r_max_x[pix_label]) r_max_x[pix_label] <= pix_x;
                        if (pix_y < r_min_y[pix_label]) r_min_y[pix_label] <= pix_y;
                        if (pix_y > r_max_y[pix_label]) r_max_y[pix_label] <= pix_y;
                    end
                end
                S_LINK: begin
                    // Linking the larger root under the smaller keeps parent[i] <= i.
                    if (r_ra > r_rb)      r_parent[r_ra] <= r_rb;
                    else if (r_rb > r_ra) r_parent[r_rb] <= r_ra;
                end
                S_FOLD: begin
                    r_parent[r_idx] <= w_root;
                    if (w_fold_move) begin
                        r_area[w_root]  <= sat_add(r_area[w_root], r_area[r_idx]);
                        r_sum_x[w_root] <= sat_add(r_sum_x[w_root], r_sum_x[r_idx]);
                        r_sum_y[w_root] <= sat_add(r_sum_y[w_root], r_sum_y[r_idx]);
                        if (r_min_x[r_idx] < r_min_x[w_root]) r_min_x[w_root] <= r_min_x[r_idx];
                        if (r_max_x[r_idx] > r_max_x[w_root]) r_max_x[w_root] <= r_max_x[r_idx];
                        if (r_min_y[r_idx] < r_min_y[w_root]) r_min_y[w_root] <= r_min_y[r_idx];
                        if (r_max_y[r_idx] > r_max_y[w_root]) r_max_y[w_root] <= r_max_y[r_idx];
                        r_area[r_idx] <= '0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ccl_object_table.sv
// Directed testbench for ccl_object_table: reset values, clear duration,
// empty frame, simple records, merge chains, merge FIFO overflow, output
// back-pressure, and reset in the middle of the fold pass.
module tb_ccl_object_table;
  localparam int LW = 8;
  localparam int CW = 16;
  localparam int AW = 32;
  localparam int RW = LW + 3*AW + 4*CW + 1;
  localparam logic [3:0] ST_CLEAR = 4'd1;
  localparam logic [3:0] ST_FOLD  = 4'd7;

  logic          clk;
  logic          reset;
  logic          frame_start;
  logic          pix_valid;
  logic [LW-1:0] pix_label;
  logic [CW-1:0] pix_x, pix_y;
  logic          merge_valid;
  logic [LW-1:0] merge_a, merge_b;
  logic          frame_end;
  logic [LW-1:0] num_labels;
  logic          busy, obj_valid, obj_ready, obj_last, frame_done, merge_overflow;
  logic [LW-1:0] obj_label;
  logic [AW-1:0] obj_area, obj_sum_x, obj_sum_y;
  logic [CW-1:0] obj_min_x, obj_max_x, obj_min_y, obj_max_y;
  logic [3:0]    dbg_state;

  int n_pass  = 0;
  int n_total = 0;
  logic [RW-1:0] exp_q[$];

  ccl_object_table dut (
    .clk(clk), .reset(reset), .frame_start(frame_start),
    .pix_valid(pix_valid), .pix_label(pix_label), .pix_x(pix_x), .pix_y(pix_y),
    .merge_valid(merge_valid), .merge_a(merge_a), .merge_b(merge_b),
    .frame_end(frame_end), .num_labels(num_labels), .busy(busy),
    .obj_valid(obj_valid), .obj_ready(obj_ready), .obj_label(obj_label),
    .obj_area(obj_area), .obj_sum_x(obj_sum_x), .obj_sum_y(obj_sum_y),
    .obj_min_x(obj_min_x), .obj_max_x(obj_max_x), .obj_min_y(obj_min_y),
    .obj_max_y(obj_max_y), .obj_last(obj_last), .frame_done(frame_done),
    .merge_overflow(merge_overflow), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [RW-1:0] mk(input int lbl, input int area, input int sx, input int sy,
                                       input int mnx, input int mxx, input int mny, input int mxy,
                                       input bit last);
    return {LW'(lbl), AW'(area), AW'(sx), AW'(sy), CW'(mnx), CW'(mxx), CW'(mny), CW'(mxy), last};
  endfunction

  function automatic logic [RW-1:0] pack_obj();
    return {obj_label, obj_area, obj_sum_x, obj_sum_y, obj_min_x, obj_max_x,
            obj_min_y, obj_max_y, obj_last};
  endfunction

  // driver tasks
  task automatic step(input bit pv, input int l, input int x, input int y,
                      input bit mv, input int a, input int b);
    pix_valid   = pv;
    pix_label   = LW'(l);
    pix_x       = CW'(x);
    pix_y       = CW'(y);
    merge_valid = mv;
    merge_a     = LW'(a);
    merge_b     = LW'(b);
    tick();
    pix_valid   = 1'b0;
    merge_valid = 1'b0;
  endtask

  task automatic wait_busy(input string tag, input bit level, input int budget);
    int c;
    c = 0;
    while ((busy !== level) && (c < budget)) begin
      tick();
      c++;
    end
    chk(tag, RW'(busy), RW'(level));
  endtask

  task automatic start_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    wait_busy("clear_end", 1'b0, 400);
  endtask

  task automatic end_frame(input int n);
    num_labels = LW'(n);
    frame_end  = 1'b1;
    tick();
    frame_end  = 1'b0;
  endtask

  // Scoreboard: every handshaken record is checked against exp_q in order.
  task automatic run_emit(input string tag, input int stall);
    int left;
    bit done, snapped, stable;
    logic [RW-1:0] snap, cur, exp;
    left = stall; done = 0; snapped = 0; stable = 1;
    obj_ready = (stall == 0);
    for (int c = 0; c < 4000 && !done; c++) begin
      cur = pack_obj();
      if (frame_done) begin
        done = 1;
      end else if (obj_valid) begin
        if (left > 0) begin
          obj_ready = 1'b0;
          if (!snapped) begin snap = cur; snapped = 1; end
          else if (cur !== snap) stable = 0;
          left--;
        end else begin
          obj_ready = 1'b1;
          exp = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
          chk({tag, "_rec"}, cur, exp);
        end
      end
      if (!done) tick();
    end
    chk({tag, "_done"}, RW'(done), RW'(1));
    chk({tag, "_missing"}, RW'(exp_q.size()), RW'(0));
    if (stall > 0) chk({tag, "_stall_stable"}, RW'(stable), RW'(1));
    obj_ready = 1'b1;
  endtask

  initial begin
    int cnt;
    reset = 1'b1; frame_start = 0; pix_valid = 0; pix_label = 0; pix_x = 0; pix_y = 0;
    merge_valid = 0; merge_a = 0; merge_b = 0; frame_end = 0; num_labels = 0; obj_ready = 1;
    tick(); tick(); tick();
    chk("rst_busy", RW'(busy), RW'(0));
    chk("rst_obj_valid", RW'(obj_valid), RW'(0));
    chk("rst_frame_done", RW'(frame_done), RW'(0));
    chk("rst_overflow", RW'(merge_overflow), RW'(0));
    chk("rst_obj", pack_obj(), RW'(0));
    chk("rst_state", RW'(dbg_state), RW'(ST_CLEAR));
    reset = 1'b0;
    wait_busy("post_rst_busy_hi", 1'b1, 5);
    wait_busy("post_rst_busy_lo", 1'b0, 400);

    // empty frame: no records, frame_done still pulses
    end_frame(0);
    run_emit("empty", 0);

    // clear lasts exactly NUM_LABELS cycles
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    cnt = 0;
    while (busy && cnt < 1000) begin
      cnt++;
      tick();
    end
    chk("clear_cycles", RW'(cnt), RW'(256));

    // frame A: two labels, back-to-back pixels, stalled output
    step(1, 1, 2, 3, 0, 0, 0);
    step(1, 1, 3, 3, 0, 0, 0);
    step(1, 1, 2, 4, 0, 0, 0);
    step(1, 2, 10, 10, 0, 0, 0);
    end_frame(3);
    exp_q.push_back(mk(1, 3, 7, 10, 2, 3, 3, 4, 0));
    exp_q.push_back(mk(2, 1, 10, 10, 10, 10, 10, 10, 1));
    run_emit("frameA", 5);

    // frame B: merge chain with duplicate and ignored pairs, pixels alongside
    start_frame();
    step(1, 1, 1, 5, 1, 2, 1);
    step(1, 2, 2, 5, 1, 4, 3);
    step(1, 3, 3, 5, 1, 3, 2);
    step(1, 4, 4, 5, 1, 2, 1);
    step(0, 0, 0, 0, 1, 3, 3);
    step(0, 0, 0, 0, 1, 0, 2);
    end_frame(5);
    exp_q.push_back(mk(1, 4, 10, 20, 1, 4, 5, 5, 1));
    run_emit("frameB", 0);

    // frame C: 65 merges into a 64-entry FIFO; the last pair (66,65) is dropped
    start_frame();
    chk("ovf_start", RW'(merge_overflow), RW'(0));
    for (int i = 1; i <= 66; i++) step(1, i, i, 1, (i <= 65), i + 1, i);
    chk("ovf_set", RW'(merge_overflow), RW'(1));
    end_frame(67);
    exp_q.push_back(mk(1, 65, 2145, 65, 1, 65, 1, 1, 0));
    exp_q.push_back(mk(66, 1, 66, 1, 66, 66, 1, 1, 1));
    run_emit("frameC", 0);
    chk("ovf_sticky", RW'(merge_overflow), RW'(1));
    start_frame();
    chk("ovf_cleared", RW'(merge_overflow), RW'(0));

    // frame D: reset in the middle of the fold pass
    for (int i = 1; i <= 10; i++) step(1, i, i, i, (i >= 2), i, i - 1);
    end_frame(11);
    cnt = 0;
    while ((dbg_state !== ST_FOLD) && cnt < 1000) begin
      cnt++;
      tick();
    end
    chk("reach_fold", RW'(dbg_state), RW'(ST_FOLD));
    tick();
    tick();
    chk("fold_busy", RW'(busy), RW'(1));
    reset = 1'b1;
    tick();
    chk("midrst_busy", RW'(busy), RW'(0));
    chk("midrst_obj_valid", RW'(obj_valid), RW'(0));
    chk("midrst_obj", pack_obj(), RW'(0));
    chk("midrst_done", RW'(frame_done), RW'(0));
    reset = 1'b0;
    wait_busy("midrst_busy_hi", 1'b1, 5);
    wait_busy("midrst_busy_lo", 1'b0, 400);

    // frame E: fresh statistics after the abandoned frame
    step(1, 1, 7, 8, 0, 0, 0);
    step(1, 3, 1, 2, 0, 0, 0);
    end_frame(4);
    exp_q.push_back(mk(1, 1, 7, 8, 7, 7, 8, 8, 0));
    exp_q.push_back(mk(3, 1, 1, 2, 1, 1, 2, 2, 1));
    run_emit("frameE", 0);
    chk("final_ovf", RW'(merge_overflow), RW'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
